// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared states, opcodes, datapath codes and decode helpers
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_JAL    = 4'd13,
    S_TRAP   = 4'd14
  } state_t;
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_BUS     = 2'b10;
  // Where DECODE sends each opcode; unknown or disabled opcodes trap
  function automatic state_t decode_op(input logic [5:0] op, input logic imm_en);
    return (op == OP_LW || op == OP_SW) ? S_MEMADR :
           op == OP_R   ? S_EXEC :
           op == OP_BEQ ? S_BEQ :
           op == OP_BNE ? S_BNE :
           op == OP_J   ? S_JUMP :
           op == OP_JAL ? S_JAL :
           (imm_en && (op == OP_ADDI || op == OP_SLTI || op == OP_ANDI || op == OP_ORI)) ? S_IMMEX :
           S_TRAP;
  endfunction
  // ALU operation for an immediate-form instruction
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    return op == OP_SLTI ? ALU_SLT :
           op == OP_ANDI ? ALU_AND :
           op == OP_ORI  ? ALU_OR  : ALU_ADD;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags the timeout limit
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  // Count while stalled; any cycle without a stall (state change) clears it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= en ? cnt + 8'd1 : '0;
  assign expired = cnt == 8'(TIMEOUT);
endmodule

// File: rtl/mips_mc_control_ws.sv
// mips_mc_control_ws: multicycle MIPS control FSM with memory wait states and traps
module mips_mc_control_ws
  import mips_ctrl_pkg::*;
#(
  parameter bit         IMM_EN       = 1'b1,
  parameter int         TIMEOUT      = 15,
  parameter logic [1:0] TRAP_VEC_SEL = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       beq,
  output logic       bne,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic [1:0] trap_cause,
  output logic [3:0] current_state
);
  state_t state, next;
  logic is_mem, expired;
  assign is_mem = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign current_state = state;
  // Stop counting once the limit is hit so TRAP starts with a cleared counter
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (is_mem && !mem_ready && !expired),
    .expired(expired)
  );
  // State register and sticky trap cause captured on entry to TRAP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_FETCH;
      trap_cause <= TC_NONE;
    end else begin
      state <= next;
      if (next == S_TRAP) trap_cause <= state == S_DECODE ? TC_ILLEGAL : TC_BUS;
    end
  // Next-state logic; mem_ready beats a simultaneous timeout
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
      S_DECODE: next = decode_op(opcode, IMM_EN);
      S_MEMADR: next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = mem_ready ? S_MEMWB : expired ? S_TRAP : S_MEMRD;
      S_MEMWR:  next = mem_ready ? S_FETCH : expired ? S_TRAP : S_MEMWR;
      S_EXEC:   next = S_ALUWB;
      S_IMMEX:  next = S_IMMWB;
      default:  next = S_FETCH;
    endcase
  end
  // Output decode from the state, with FETCH enables qualified by mem_ready
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = RD_RT;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: mem_req = 1'b1;
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op(opcode);
      end
      S_IMMWB: reg_write = 1'b1;
      S_BEQ, S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        beq       = state == S_BEQ;
        bne       = state == S_BNE;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        reg_dst   = RD_RA;
      end
      S_TRAP: begin
        pc_src   = TRAP_VEC_SEL;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_control_ws.sv
// tb_mips_mc_control_ws: directed scoreboard bench for the multicycle control FSM
module tb_mips_mc_control_ws;
  import mips_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_req, mem_write, ir_write, pc_write, beq, bne, reg_write, mem_to_reg, alu_src_a;
  logic [1:0] reg_dst, alu_src_b, pc_src, trap_cause;
  logic [2:0] alu_op;
  logic [3:0] current_state;
  typedef struct packed {
    logic [3:0]  st;
    logic [1:0]  cause;
    logic [17:0] outs;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;
  logic [1:0] exp_cause = TC_NONE;
  logic [17:0] dut_outs;
  assign dut_outs = {mem_req, mem_write, ir_write, pc_write, beq, bne, reg_write, mem_to_reg,
                     alu_src_a, reg_dst, alu_src_b, pc_src, alu_op};

  mips_mc_control_ws dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .beq(beq), .bne(bne), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .reg_dst(reg_dst), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .trap_cause(trap_cause), .current_state(current_state)
  );

  always #5 clk = ~clk;

  // Output table per state, written straight from the state descriptions
  function automatic logic [17:0] spec_outs(input int st, input logic [5:0] op, input logic rdy);
    logic mr, mw, ir, pw, bq, bn, rw, m2r, asa;
    logic [1:0] rd, asb, pcs;
    logic [2:0] aop;
    {mr, mw, ir, pw, bq, bn, rw, m2r, asa} = 9'b0;
    {rd, asb, pcs} = 6'b0;
    aop = 3'b000;
    case (st)
      0:  begin mr = 1'b1; asb = 2'b01; ir = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  mr = 1'b1;
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mr = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; aop = 3'b010; end
      7:  begin rw = 1'b1; rd = 2'b01; end
      8:  begin asa = 1'b1; aop = 3'b001; pcs = 2'b01; bq = 1'b1; end
      9:  begin asa = 1'b1; aop = 3'b001; pcs = 2'b01; bn = 1'b1; end
      10: begin pcs = 2'b10; pw = 1'b1; end
      11: begin
        asa = 1'b1; asb = 2'b10;
        aop = op == 6'd10 ? 3'b101 : op == 6'd12 ? 3'b011 : op == 6'd13 ? 3'b100 : 3'b000;
      end
      12: rw = 1'b1;
      13: begin pcs = 2'b10; pw = 1'b1; rw = 1'b1; rd = 2'b10; end
      14: begin pcs = 2'b11; pw = 1'b1; end
      default: ;
    endcase
    return {mr, mw, ir, pw, bq, bn, rw, m2r, asa, rd, asb, pcs, aop};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during it
  task automatic step(input logic [5:0] op, input int rdy, input int st, input int rs = 1);
    exp_t e;
    opcode    = op;
    mem_ready = rdy != 0;
    rst_n     = rs != 0;
    e.st      = 4'(st);
    e.cause   = exp_cause;
    e.outs    = spec_outs(st, op, rdy != 0);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, pop the expectation for this cycle and compare
  always @(negedge clk)
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks += 3;
      if (current_state !== mon_e.st) begin
        errors++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, current_state, mon_e.st);
      end
      if (dut_outs !== mon_e.outs) begin
        errors++;
        $display("FAIL outputs t=%0t state=%0d got=%b exp=%b", $time, current_state, dut_outs, mon_e.outs);
      end
      if (trap_cause !== mon_e.cause) begin
        errors++;
        $display("FAIL trap_cause t=%0t got=%b exp=%b", $time, trap_cause, mon_e.cause);
      end
    end

  logic [5:0] imm_ops [4];

  initial begin
    imm_ops = '{OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
    @(posedge clk);
    #1;
    step(OP_R, 0, 0, 0);
    step(OP_R, 1, 0, 0);
    // LW, no wait states
    step(OP_LW, 1, 0); step(OP_LW, 1, 1); step(OP_LW, 1, 2); step(OP_LW, 1, 3); step(OP_LW, 1, 4);
    // SW with three wait cycles in MEMWR
    step(OP_SW, 1, 0); step(OP_SW, 1, 1); step(OP_SW, 1, 2);
    for (int i = 0; i < 3; i++) step(OP_SW, 0, 5);
    step(OP_SW, 1, 5);
    // R-type
    step(OP_R, 1, 0); step(OP_R, 1, 1); step(OP_R, 1, 6); step(OP_R, 1, 7);
    // Immediate ALU ops
    foreach (imm_ops[k]) begin
      step(imm_ops[k], 1, 0); step(imm_ops[k], 1, 1); step(imm_ops[k], 1, 11); step(imm_ops[k], 1, 12);
    end
    // Branches and jumps
    step(OP_BEQ, 1, 0); step(OP_BEQ, 1, 1); step(OP_BEQ, 1, 8);
    step(OP_BNE, 1, 0); step(OP_BNE, 1, 1); step(OP_BNE, 1, 9);
    step(OP_J, 1, 0);   step(OP_J, 1, 1);   step(OP_J, 1, 10);
    step(OP_JAL, 1, 0); step(OP_JAL, 1, 1); step(OP_JAL, 1, 13);
    // Illegal opcode
    step(6'd9, 1, 0); step(6'd9, 1, 1);
    exp_cause = TC_ILLEGAL;
    step(6'd9, 1, 14);
    // FETCH timeout: 16 stalled cycles then TRAP
    for (int i = 0; i < 16; i++) step(OP_R, 0, 0);
    exp_cause = TC_BUS;
    step(OP_R, 0, 14);
    // mem_ready exactly at counter==TIMEOUT completes normally (FETCH)
    for (int i = 0; i < 15; i++) step(OP_R, 0, 0);
    step(OP_R, 1, 0); step(OP_R, 1, 1); step(OP_R, 1, 6); step(OP_R, 1, 7);
    // Same boundary inside MEMRD
    step(OP_LW, 1, 0); step(OP_LW, 1, 1); step(OP_LW, 1, 2);
    for (int i = 0; i < 15; i++) step(OP_LW, 0, 3);
    step(OP_LW, 1, 3); step(OP_LW, 1, 4);
    // Reset during a MEMRD wait
    step(OP_LW, 1, 0); step(OP_LW, 1, 1); step(OP_LW, 1, 2); step(OP_LW, 0, 3); step(OP_LW, 0, 3);
    exp_cause = TC_NONE;
    step(OP_LW, 0, 0, 0);
    step(OP_LW, 1, 0); step(OP_LW, 1, 1); step(OP_LW, 1, 2); step(OP_LW, 1, 3); step(OP_LW, 1, 4);
    // Timeout again after reset: counter must start from zero
    for (int i = 0; i < 16; i++) step(OP_R, 0, 0);
    exp_cause = TC_BUS;
    step(OP_R, 0, 14);
    step(OP_R, 1, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_mc_control_ws.md
# mips_mc_control_ws

Next-generation multicycle MIPS control FSM, sitting between the instruction register opcode field and the datapath mux selects and enables. It extends the base control sequencer with immediate-ALU and JAL instructions and a memory wait-state handshake (`mem_req`/`mem_ready`). It also adds a bounded wait-state timeout and a trap state for illegal opcodes and bus errors, with a sticky cause register.

## Interface
- `IMM_EN`, 1: 1 decodes ADDI/SLTI/ANDI/ORI; 0 treats them as illegal
- `TIMEOUT`, 15: max wait cycles in one memory state before bus error (range 1..255)
- `TRAP_VEC_SEL`, 2'b11: `pc_src` code selecting the exception vector
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `opcode` in 6: instruction opcode, stable from DECODE onward
- `mem_ready` in 1: memory completes the current access this cycle
- `mem_req` out 1: memory access requested
- `mem_write` out 1: access is a write
- `ir_write`, `pc_write`, `beq`, `bne`, `reg_write`, `mem_to_reg`, `alu_src_a` out 1 each: datapath enables and selects
- `reg_dst` out 2: destination register select: 00 rt, 01 rd, 10 $31
- `alu_src_b`, `pc_src` out 2 each: datapath mux selects
- `alu_op` out 3: ALU operation: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- `trap_cause` out 2: sticky trap cause: 00 none, 01 illegal opcode, 10 bus error
- `current_state` out 4: state encoding, for debug and coverage

## Operation
- Opcodes: R=0, J=2, JAL=3, BEQ=4, BNE=5, ADDI=8, SLTI=10, ANDI=12, ORI=13, LW=35, SW=43.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, BNE 9, JUMP 10, IMMEX 11, IMMWB 12, JAL 13, TRAP 14.
- FETCH:
  - drives `mem_req`=1, `alu_src_b`=01, `alu_op`=add.
  - Holds until `mem_ready`; `ir_write`=`pc_write`=`mem_ready` (Mealy-qualified).
  - Goes to DECODE on `mem_ready`.
- DECODE: `alu_src_b`=11, `alu_op`=add. Next state by opcode:
  - LW/SW → MEMADR
  - R → EXEC
  - BEQ → BEQ; BNE → BNE
  - J → JUMP; JAL → JAL
  - immediate ops with IMM_EN=1 → IMMEX
  - anything else → TRAP, cause 01
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD / MEMWR:
  - `mem_req`=1; `mem_write`=1 in MEMWR only.
  - Stays until `mem_ready`, then MEMRD → MEMWB and MEMWR → FETCH.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=00. Goes to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=funct. Goes to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=01. Goes to FETCH.
- IMMEX:
  - `alu_src_a`=1, `alu_src_b`=10.
  - `alu_op`: ADDI→add, SLTI→slt, ANDI→and, ORI→or.
  - Goes to IMMWB.
- IMMWB: `reg_write`=1, `reg_dst`=00. Goes to FETCH.
- BEQ / BNE: `alu_src_a`=1, `alu_op`=sub, `pc_src`=01; `beq`=1 or `bne`=1 respectively. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_write`=1. Goes to FETCH.
- JAL:
  - `pc_src`=10, `pc_write`=1, `reg_write`=1, `reg_dst`=10.
  - `mem_to_reg`=0; the datapath routes PC+4 when `reg_dst`=10.
  - Goes to FETCH.
- TRAP: `pc_src`=TRAP_VEC_SEL, `pc_write`=1 for exactly one cycle. Goes to FETCH.
- Wait counter (8-bit):
  - Clears on entry to any memory state (FETCH, MEMRD, MEMWR).
  - Increments each cycle the state is held with `mem_ready`=0.
  - When the counter equals TIMEOUT and `mem_ready`=0: go to TRAP with cause 10, no enables asserted.
  - `mem_ready` on the same cycle the counter reaches TIMEOUT wins; the access completes normally.
- `trap_cause` is written on entry to TRAP and held until the next trap or reset.
- Every output not listed for a state is 0.

## Timing
- Reset (`rst_n`=0): state=FETCH, counter=0, `trap_cause`=00.
  - Outputs are the FETCH values with `mem_ready` qualification: `mem_req`=1, `alu_src_b`=01; all else 0.
- Reset mid-access abandons the access; the first request after release is a FETCH.
- Instruction latency with zero wait states (`mem_ready` held 1):
  - R, immediate, LW-less: 4 cycles; SW: 4; LW: 5.
  - BEQ, BNE, J, JAL: 3.
- Each memory wait cycle adds 1 cycle.
- Bus-error trap: entered TIMEOUT+1 cycles after entering the memory state; TRAP adds 1 cycle.
- All outputs are combinational from the state register, plus `mem_ready` for `ir_write`/`pc_write` in FETCH; no output depends on `opcode` except `alu_op` in IMMEX.

## Structure
- Package `mips_ctrl_pkg`:
  - state enum (4-bit)
  - opcode localparams
  - `alu_op` codes, `reg_dst` codes, trap cause codes
- Shared by datapath and bench.
- One sub-module, `mem_wait_timer`: counter, clear, enable, timeout compare.
- FSM: separate state register, next-state logic and output decode.

## Test plan
- LW with `mem_ready`=1 always → states 0,1,2,3,4,0; `reg_write` and `mem_to_reg` high only in state 4.
- SW with 3 wait cycles in MEMWR → state 5 held 4 cycles, `mem_write`=1 throughout, then FETCH.
- FETCH with `mem_ready`=0 for 16 cycles, TIMEOUT=15 → TRAP, `pc_src`=11 and `pc_write`=1 for one cycle, `trap_cause`=10; `ir_write` never asserted.
- Opcode 6'd9 (illegal) → DECODE→TRAP, `trap_cause`=01. ANDI with IMM_EN=1 → IMMEX `alu_op`=011, IMMWB `reg_dst`=00.
- JAL → state 13: `pc_write`=1, `reg_write`=1, `reg_dst`=10. BNE → state 9: `bne`=1, `alu_op`=001.
- `rst_n` asserted during MEMRD wait → immediately FETCH, `trap_cause`=00, counter 0; `mem_ready` at counter=TIMEOUT → normal completion, no trap.
